// File: rtl/spi_link_pkg.sv
// Shared constants and types for the 40-bit board SPI link.
package spi_link_pkg;

  localparam int FRAME_BITS   = 40;
  localparam int DAC_PAD_BITS = 8;
  localparam int ADDR_BITS    = 7;
  localparam int DATA_BITS    = 32;
  localparam int DAC_BITS     = FRAME_BITS - DAC_PAD_BITS;
  localparam int RW_BIT       = 39;
  localparam int RESP_ERR_BIT = 39;

  typedef enum logic {
    FRAME_CFG = 1'b0,
    FRAME_DAC = 1'b1
  } frame_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } resp_state_e;

endpackage

// File: rtl/spi_responder_if.sv
// Link-side signal bundle of the SPI responder. The master side is the link
// controller plus the external register bank; the slave side is the responder.
interface spi_responder_if;
  import spi_link_pkg::*;

  logic                 cs_b;
  logic                 mosi;
  logic                 spi_sel;
  logic                 miso;
  logic                 cfg_wr;
  logic [ADDR_BITS-1:0] cfg_addr;
  logic [DATA_BITS-1:0] cfg_wdata;
  logic [ADDR_BITS-1:0] cfg_rd_addr;
  logic [DATA_BITS-1:0] cfg_rd_data;
  logic                 dac_valid;
  logic [DAC_BITS-1:0]  dac_code;
  logic                 frame_err;

  modport master (
    output cs_b, mosi, spi_sel, cfg_rd_data,
    input  miso, cfg_wr, cfg_addr, cfg_wdata, cfg_rd_addr, dac_valid, dac_code, frame_err
  );

  modport slave (
    input  cs_b, mosi, spi_sel, cfg_rd_data,
    output miso, cfg_wr, cfg_addr, cfg_wdata, cfg_rd_addr, dac_valid, dac_code, frame_err
  );

endinterface

// File: rtl/spi_frame_shifter.sv
// Receive/transmit shift registers and saturating bit counter of the SPI
// responder. The transmit register reloads the response while cs_b is high so
// its MSB is already on miso before the first sample edge of a frame.
module spi_frame_shifter #(
  parameter int FRAME_BITS = 40,
  parameter int CNT_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_b,
  input  logic                  mosi,
  input  logic [FRAME_BITS-1:0] resp,
  output logic [FRAME_BITS-1:0] rx_shift,
  output logic                  tx_msb,
  output logic [CNT_BITS-1:0]   bit_cnt,
  output logic                  first_bit
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(FRAME_BITS + 1);

  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  cs_b_prev_q, cs_b_prev_d;

  // cs_b_prev resets low so a frame already in progress at reset is ignored
  // until cs_b has been seen high again.
  assign first_bit = ~cs_b & cs_b_prev_q;
  assign rx_shift  = rx_q;
  assign tx_msb    = tx_q[FRAME_BITS-1];
  assign bit_cnt   = cnt_q;

  // Shift while selected, preload the response while deselected.
  always_comb begin
    rx_d        = rx_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    cs_b_prev_d = cs_b;
    if (cs_b) begin
      tx_d = resp;
    end else begin
      rx_d = {rx_q[FRAME_BITS-2:0], mosi};
      tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
      if (first_bit) begin
        cnt_d = CNT_BITS'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q        <= '0;
      tx_q        <= '0;
      cnt_q       <= '0;
      cs_b_prev_q <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      cs_b_prev_q <= cs_b_prev_d;
    end
  end

endmodule

// File: rtl/spi_responder.sv
// Target-side endpoint of the 40-bit board SPI link: decodes config and DAC
// frames, drives register/DAC strobes and returns a 40-bit response on miso.
// Build option SPI_RESPONDER_ECHO_EN: the response becomes the raw 40 bits of
// the last completed frame (loopback) instead of register read data.
module spi_responder #(
  parameter int FRAME_BITS = spi_link_pkg::FRAME_BITS,
  parameter int NUM_REGS   = 16,
  parameter int DAC_BITS   = spi_link_pkg::DAC_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_responder_if.slave  bus
);
  import spi_link_pkg::*;

  localparam int CNT_BITS = $clog2(FRAME_BITS + 2);

  logic [FRAME_BITS-1:0] rx_shift;
  logic                  tx_msb;
  logic [CNT_BITS-1:0]   bit_cnt;
  logic                  first_bit;

  resp_state_e           state_q, state_d;
  frame_type_e           sel_q, sel_d;
  logic                  err_flag_q, err_flag_d;
  logic [FRAME_BITS-1:0] resp_q, resp_d;
  logic                  cfg_wr_q, cfg_wr_d;
  logic [ADDR_BITS-1:0]  cfg_addr_q, cfg_addr_d;
  logic [DATA_BITS-1:0]  cfg_wdata_q, cfg_wdata_d;
  logic [ADDR_BITS-1:0]  cfg_rd_addr_q, cfg_rd_addr_d;
  logic                  dac_valid_q, dac_valid_d;
  logic [DAC_BITS-1:0]   dac_code_q, dac_code_d;
  logic                  frame_err_q, frame_err_d;

  logic [ADDR_BITS-1:0]  rx_addr;
  logic                  addr_ok;
  logic                  rd_ok;

  spi_frame_shifter #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_BITS   (CNT_BITS)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_b      (bus.cs_b),
    .mosi      (bus.mosi),
    .resp      (resp_q),
    .rx_shift  (rx_shift),
    .tx_msb    (tx_msb),
    .bit_cnt   (bit_cnt),
    .first_bit (first_bit)
  );

  assign rx_addr = rx_shift[RW_BIT-1 -: ADDR_BITS];
  assign addr_ok = 32'(rx_addr) < NUM_REGS;
  assign rd_ok   = 32'(cfg_rd_addr_q) < NUM_REGS;

  assign bus.miso        = bus.cs_b ? 1'b0 : tx_msb;
  assign bus.cfg_wr      = cfg_wr_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.cfg_wdata   = cfg_wdata_q;
  assign bus.cfg_rd_addr = cfg_rd_addr_q;
  assign bus.dac_valid   = dac_valid_q;
  assign bus.dac_code    = dac_code_q;
  assign bus.frame_err   = frame_err_q;

  // Frame FSM: decode on the first deselected edge, refresh the response one
  // cycle later once the register bank has answered the new read address.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    err_flag_d    = err_flag_q;
    resp_d        = resp_q;
    cfg_wr_d      = 1'b0;
    cfg_addr_d    = cfg_addr_q;
    cfg_wdata_d   = cfg_wdata_q;
    cfg_rd_addr_d = cfg_rd_addr_q;
    dac_valid_d   = 1'b0;
    dac_code_d    = dac_code_q;
    frame_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (first_bit) begin
          state_d = ST_SHIFT;
          sel_d   = frame_type_e'(bus.spi_sel);
        end
      end
      ST_SHIFT: begin
        if (bus.cs_b) begin
          state_d = ST_COMMIT;
          if (bit_cnt != CNT_BITS'(FRAME_BITS)) begin
            frame_err_d = 1'b1;
            err_flag_d  = 1'b1;
          end else if (sel_q == FRAME_CFG) begin
            if (rx_shift[RW_BIT]) begin
              if (addr_ok) begin
                cfg_wr_d    = 1'b1;
                cfg_addr_d  = rx_addr;
                cfg_wdata_d = rx_shift[DATA_BITS-1:0];
              end else begin
                err_flag_d = 1'b1;
              end
            end else begin
              cfg_rd_addr_d = rx_addr;
              if (!addr_ok) begin
                err_flag_d = 1'b1;
              end
            end
          end else if (rx_shift[FRAME_BITS-DAC_BITS-1:0] == '0) begin
            dac_code_d  = rx_shift[FRAME_BITS-1 -: DAC_BITS];
            dac_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d    = ST_IDLE;
        err_flag_d = 1'b0;
`ifdef SPI_RESPONDER_ECHO_EN
        resp_d = rx_shift;
`else
        resp_d = '0;
        resp_d[RESP_ERR_BIT] = err_flag_q;
        resp_d[RESP_ERR_BIT-1 -: ADDR_BITS] = cfg_rd_addr_q;
        if (rd_ok) begin
          resp_d[DATA_BITS-1:0] = bus.cfg_rd_data;
        end
`endif
        if (first_bit) begin
          state_d = ST_SHIFT;
          sel_d   = frame_type_e'(bus.spi_sel);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= FRAME_CFG;
      err_flag_q    <= 1'b0;
      resp_q        <= '0;
      cfg_wr_q      <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_wdata_q   <= '0;
      cfg_rd_addr_q <= '0;
      dac_valid_q   <= 1'b0;
      dac_code_q    <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      err_flag_q    <= err_flag_d;
      resp_q        <= resp_d;
      cfg_wr_q      <= cfg_wr_d;
      cfg_addr_q    <= cfg_addr_d;
      cfg_wdata_q   <= cfg_wdata_d;
      cfg_rd_addr_q <= cfg_rd_addr_d;
      dac_valid_q   <= dac_valid_d;
      dac_code_q    <= dac_code_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Testbench for spi_responder: table of frames driven one bit per clock, with
// expected miso words and strobes queued as each frame is driven and checked
// as the responder produces them. Honours SPI_RESPONDER_ECHO_EN for the
// expected response contents.
module tb_spi_responder;
  import spi_link_pkg::*;

  localparam logic [2:0] EV_NONE = 3'b000;
  localparam logic [2:0] EV_WR   = 3'b100;
  localparam logic [2:0] EV_DAC  = 3'b010;
  localparam logic [2:0] EV_ERR  = 3'b001;

  typedef struct {
    logic [39:0] data;
    int          nbits;
    logic        sel;
    int          gap;
    logic [2:0]  exp_kind;
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  typedef struct {
    logic [2:0]  kind;
    logic [6:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int check_count = 0;
  int pass_count  = 0;

  vec_t        vecs[$];
  ev_t         ev_q[$];
  logic [39:0] miso_q[$];
  ev_t         mon_ev;

  logic [39:0] m_rx;
  logic [39:0] m_resp;
  logic [39:0] m_resp_prev;
  logic        m_err;
  logic [6:0]  m_rd_addr;
  logic [31:0] last_dac;
  logic        short_gap;

  spi_responder_if bus();

  spi_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bank_val(input int i);
    if (i == 5) return 32'hCAFE_F00D;
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  // Register bank stand-in: zero-latency read, junk outside the implemented range.
  assign bus.cfg_rd_data = (bus.cfg_rd_addr < 7'd16) ? bank_val(32'(bus.cfg_rd_addr)) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic resetModel();
    m_rx        = '0;
    m_resp      = '0;
    m_resp_prev = '0;
    m_err       = 1'b0;
    m_rd_addr   = '0;
    last_dac    = '0;
    short_gap   = 1'b0;
  endtask

  // Reference behaviour of the frame decode and the next response word.
  task automatic modelCommit(input int nbits, input logic sel);
    logic [6:0] a;
    a = m_rx[38:32];
    m_resp_prev = m_resp;
    if (nbits != 40) m_err = 1'b1;
    else if (!sel) begin
      if (m_rx[39]) begin
        if (a >= 7'd16) m_err = 1'b1;
      end else begin
        m_rd_addr = a;
        if (a >= 7'd16) m_err = 1'b1;
      end
    end
`ifdef SPI_RESPONDER_ECHO_EN
    m_resp = m_rx;
`else
    m_resp = {m_err, m_rd_addr, (m_rd_addr < 7'd16) ? bank_val(32'(m_rd_addr)) : 32'h0};
`endif
    m_err = 1'b0;
  endtask

  task automatic addVec(input logic [39:0] data, input int nbits, input logic sel, input int gap,
                        input logic [2:0] kind, input logic [6:0] addr, input logic [31:0] edata,
                        input string name);
    vec_t v;
    v.data = data; v.nbits = nbits; v.sel = sel; v.gap = gap;
    v.exp_kind = kind; v.exp_addr = addr; v.exp_data = edata; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [39:0] exp_miso;
    logic [39:0] got_miso;
    logic [39:0] mask;
    ev_t e;
    got_miso = '0;
    mask     = '0;
    miso_q.push_back(short_gap ? m_resp_prev : m_resp);
    if (v.exp_kind != EV_NONE) begin
      e.kind = v.exp_kind; e.addr = v.exp_addr; e.data = v.exp_data;
      ev_q.push_back(e);
    end
    for (int i = 0; i < v.nbits; i++) begin
      @(negedge clk);
      bus.cs_b    = 1'b0;
      bus.spi_sel = v.sel;
      bus.mosi    = (i < 40) ? v.data[39-i] : 1'b0;
      #1;
      if (i < 40) begin
        got_miso[39-i] = bus.miso;
        mask[39-i]     = 1'b1;
      end
      m_rx = {m_rx[38:0], bus.mosi};
    end
    @(negedge clk);
    bus.cs_b = 1'b1;
    bus.mosi = 1'b0;
    modelCommit(v.nbits, v.sel);
    short_gap = (v.gap < 3);
    repeat (v.gap - 1) @(negedge clk);
    #2;
    exp_miso = miso_q.pop_front();
    checkOutput({v.name, "_miso"}, 64'(got_miso & mask), 64'(exp_miso & mask));
    checkOutput({v.name, "_strobes"}, 64'(ev_q.size()), 64'd0);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.cfg_wr || bus.dac_valid || bus.frame_err)) begin
      if (ev_q.size() == 0) begin
        checkOutput("unexpected_strobe", 64'({bus.cfg_wr, bus.dac_valid, bus.frame_err}), 64'd0);
      end else begin
        mon_ev = ev_q.pop_front();
        checkOutput("strobe_kind", 64'({bus.cfg_wr, bus.dac_valid, bus.frame_err}), 64'(mon_ev.kind));
        if (mon_ev.kind == EV_WR) begin
          checkOutput("cfg_addr", 64'(bus.cfg_addr), 64'(mon_ev.addr));
          checkOutput("cfg_wdata", 64'(bus.cfg_wdata), 64'(mon_ev.data));
        end else if (mon_ev.kind == EV_DAC) begin
          checkOutput("dac_code", 64'(bus.dac_code), 64'(mon_ev.data));
          last_dac = mon_ev.data;
        end else begin
          checkOutput("dac_code_held", 64'(bus.dac_code), 64'(last_dac));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cs_b    = 1'b1;
    bus.mosi    = 1'b0;
    bus.spi_sel = 1'b0;
    rst_n       = 1'b0;
    resetModel();

    addVec(40'h85_1234_5678, 40, 1'b0, 4, EV_WR,   7'd5,  32'h1234_5678, "wr5");
    addVec(40'h05_0000_0000, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "rd5");
    addVec(40'h81_0000_0011, 40, 1'b0, 4, EV_WR,   7'd1,  32'h0000_0011, "wr1");
    addVec(40'hAB_CD01_2300, 40, 1'b1, 4, EV_DAC,  7'd0,  32'hABCD_0123, "dac");
    addVec(40'h12_3456_7801, 40, 1'b1, 4, EV_ERR,  7'd0,  32'h0,         "dac_pad");
    addVec(40'h03_0000_0000, 39, 1'b0, 4, EV_ERR,  7'd0,  32'h0,         "short39");
    addVec(40'h03_0000_0000, 41, 1'b0, 4, EV_ERR,  7'd0,  32'h0,         "long41");
    addVec(40'h03_0000_0000, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "rd3");
    addVec(40'h20_0000_0000, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "rd20");
    addVec(40'hA0_DEAD_BEEF, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "wr20");
    addVec(40'h05_0000_0000, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "rd5b");
    addVec(40'h11_2233_4400, 40, 1'b1, 4, EV_DAC,  7'd0,  32'h1122_3344, "dac2");
    addVec(40'h0F_0000_0000, 40, 1'b0, 2, EV_NONE, 7'd0,  32'h0,         "rd15_gap2");
    addVec(40'h8F_0BAD_CAFE, 40, 1'b0, 4, EV_WR,   7'd15, 32'h0BAD_CAFE, "wr15_stale");
    addVec(40'h12_3456_789A, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "rd12");
    addVec(40'h00_0000_0000, 40, 1'b0, 4, EV_NONE, 7'd0,  32'h0,         "rd0");

    // Reset state, including miso with the frame selected.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs", 64'({bus.cfg_wr, bus.cfg_addr, bus.cfg_wdata, bus.cfg_rd_addr,
                                      bus.dac_valid, bus.frame_err, bus.miso}), 64'd0);
    checkOutput("reset_dac_code", 64'(bus.dac_code), 64'd0);
    bus.cs_b = 1'b0;
    #1;
    checkOutput("reset_miso_selected", 64'(bus.miso), 64'd0);
    bus.cs_b = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Mid-frame reset: 20 bits of a write, then reset while still selected.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.cs_b    = 1'b0;
      bus.spi_sel = 1'b0;
      bus.mosi    = ((i % 3) == 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_outputs", 64'({bus.cfg_wr, bus.cfg_addr, bus.cfg_wdata, bus.cfg_rd_addr,
                                       bus.dac_valid, bus.frame_err, bus.miso}), 64'd0);
    checkOutput("midrst_dac_code", 64'(bus.dac_code), 64'd0);
    bus.cs_b = 1'b1;
    bus.mosi = 1'b0;
    rst_n    = 1'b1;
    resetModel();
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_strobe", 64'(ev_q.size()), 64'd0);

    begin
      vec_t v;
      v.data = 40'h84_0000_BEEF; v.nbits = 40; v.sel = 1'b0; v.gap = 4;
      v.exp_kind = EV_WR; v.exp_addr = 7'd4; v.exp_data = 32'h0000_BEEF; v.name = "post_rst_wr4";
      applyStimulus(v);
      v.data = 40'h00_0000_0000; v.exp_kind = EV_NONE; v.exp_addr = 7'd0; v.exp_data = 32'h0;
      v.name = "post_rst_rd0";
      applyStimulus(v);
    end

    repeat (4) @(negedge clk);
    checkOutput("final_queue_empty", 64'(ev_q.size() + miso_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- Target-side endpoint of the 40-bit board SPI link. Runs on the same `clk` as the link controller.
- Samples `cs_b`, `mosi` and `spi_sel` synchronously and decodes two frame types:
  - config frames, which become register read/write requests;
  - DAC frames, which become a DAC-code strobe.
- Returns a 40-bit response on `miso` during each frame. Used as the on-FPGA emulation of the analog front-end and as the loopback target in system benches.

Parameters:
- FRAME_BITS, 40, bits per frame; the counter is sized from this.
- NUM_REGS, 16, number of implemented config addresses (0..NUM_REGS-1).
- DAC_BITS, 32, width of the DAC code carried in frame bits [39:8].

Ports:
- clk  in  1  system clock; all sampling on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cs_b  in  1  frame select, active low; sampled each clk.
- mosi  in  1  serial data in, MSB first; valid on each clk edge where cs_b=0.
- spi_sel  in  1  0 = config frame, 1 = DAC frame; stable while cs_b=0.
- miso  out  1  serial response, MSB first; combinational: cs_b ? 0 : tx_shift[39].
- cfg_wr  out  1  one-cycle write strobe.
- cfg_addr  out  7  write address.
- cfg_wdata  out  32  write data.
- cfg_rd_addr  out  7  registered read address to the external register bank.
- cfg_rd_data  in  32  combinational (zero-latency) read data for cfg_rd_addr.
- dac_valid  out  1  one-cycle DAC-code strobe.
- dac_code  out  DAC_BITS  last accepted DAC code; held until the next accepted DAC frame.
- frame_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0 (miso is 0 via cs_b-high or cleared tx_shift).
  - rx_shift, tx_shift, bit_cnt, resp and err_flag are cleared.
- Receive:
  - On each edge with cs_b=0: rx_shift <= {rx_shift[38:0], mosi}.
  - bit_cnt increments and saturates at FRAME_BITS+1.
  - spi_sel is latched on the first bit edge.
- Transmit:
  - On each edge with cs_b=1: tx_shift <= resp (preload).
  - On each edge with cs_b=0: tx_shift shifts left, zero fill.
  - Result: bit 39 of resp is on miso before the first sample edge.
- Frame end (first edge with cs_b=1 after a low period) — state machine IDLE -> SHIFT -> COMMIT -> IDLE; COMMIT lasts one cycle and evaluates the frame:
  - bit_cnt != FRAME_BITS: frame_err=1, err_flag<=1, nothing committed.
  - Config frame, rx[39]=1 (write), addr=rx[38:32] < NUM_REGS: cfg_wr=1, cfg_addr=rx[38:32], cfg_wdata=rx[31:0].
  - Config frame, rx[39]=0 (read): cfg_rd_addr<=rx[38:32].
  - Config frame, any address >= NUM_REGS: no strobe, err_flag<=1, no frame_err.
  - DAC frame with rx[7:0]=0: dac_code<=rx[39:8], dac_valid=1.
  - DAC frame with rx[7:0]!=0: frame_err=1, discarded.
- Response update, the cycle after COMMIT:
  - resp <= {err_flag, cfg_rd_addr, cfg_rd_data}.
  - If cfg_rd_addr >= NUM_REGS, the data field is 32'h0.
  - err_flag clears once copied into resp.
  - Reads are therefore pipelined: frame N returns data addressed by the last read in frames <= N-1.
- Timing requirement: cs_b must stay high >= 3 clk between frames. A shorter gap sends the stale resp (bench checks this; RTL does not flag it).
- Mid-frame reset: the frame is discarded, no strobe, and cs_b must return high before the next frame is decoded.
- DAC frames do not modify cfg_rd_addr.

Optional Feature:
- SPI_RESPONDER_ECHO_EN defined: resp is loaded with the full 40-bit rx_shift of the last complete frame (valid or not) instead of read data. Used for link loopback tests.
- Undefined: normal register-read response as above.

Decomposition:
- Shared package `spi_link_pkg`:
  - FRAME_BITS, DAC pad width (8), address width (7);
  - frame-type encoding (CFG=0, DAC=1);
  - RW bit index 39;
  - response error-bit index 39.
- One natural sub-module, `spi_frame_shifter`: rx/tx shift registers, bit counter and preload. The decode/commit FSM and response logic stay in the top.

Test Plan:
1. Config write 40'h85_1234_5678 (rw=1, addr 5), 1 bit/clk -> cfg_wr pulse, cfg_addr=5, cfg_wdata=32'h12345678, no frame_err.
2. Read addr 5 (40'h05_0000_0000), then any second frame with bank[5]=32'hCAFEF00D -> second frame's miso = 40'h05_CAFE_F00D.
3. DAC frame spi_sel=1, 40'hABCD_0123_00 -> dac_valid once, dac_code=32'hABCD0123. Pad 8'h01 -> frame_err, dac_code unchanged.
4. cs_b raised after 39 bits, then after 41 bits -> frame_err each time, no strobes. The next response has bit 39=1; the one after has bit 39=0.
5. Write to addr 7'h20 -> no cfg_wr, next response error bit=1. Read 7'h20 -> data field 0.
6. rst_n low mid-frame (bit 20) -> all outputs 0, no strobe. A subsequent full write frame is accepted normally. With SPI_RESPONDER_ECHO_EN, frame 40'h12_3456_789A is echoed on the next frame's miso.
